// File: rtl/richie_jr_pkg.sv
// Shared definitions for the Richie Jr fetch/execute path: default widths,
// the two opcodes the fetch unit cares about, and the fetch FSM encoding.
package richie_jr_pkg;

   localparam int ADDR_W_DEF  = 4;
   localparam int INSTR_W_DEF = 8;

   localparam logic [3:0] OP_JMP = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_HOLD    = 3'd2,
      ST_WAIT_PC = 3'd3,
      ST_HALT    = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/instr_predecode.sv
// Combinational predecode of an instruction word: flags the control-flow
// opcodes and extracts the jump target. Shared with the execute stage.
module instr_predecode
   import richie_jr_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic [INSTR_W-1:0] ir,
   output logic               is_jmp,
   output logic               is_hlt,
   output logic [ADDR_W-1:0]  jmp_target
);

   logic [3:0] opcode;

   assign opcode     = ir[INSTR_W-1 -: 4];
   assign is_jmp     = (opcode == OP_JMP);
   assign is_hlt     = (opcode == OP_HLT);
   assign jmp_target = ir[ADDR_W-1:0];

endmodule

// File: rtl/instr_fetch.sv
// Richie Jr instruction fetch unit. Reads program memory at the PC over a
// req/ack handshake, holds the word in ir for the execute stage and pulses
// the PC increment / jump-load controls when the instruction is consumed.
// Build option: define FETCH_TIMEOUT_EN to add a mem_ack watchdog that
// halts the unit and raises the sticky fetch_err flag after TIMEOUT stalled
// FETCH cycles. Without it FETCH waits forever and fetch_err is tied low.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | mem_req high, waiting for mem_ack
// HOLD    | ir valid, waiting for ir_ready
// WAIT_PC | one cycle for the PC to settle after its pulse
// HALT    | stopped; only reset leaves
module instr_fetch
   import richie_jr_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
`ifdef FETCH_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 15
`endif
) (
   input  logic               clk,
   input  logic               res_n,
   input  logic               start,
   input  logic [ADDR_W-1:0]  pc_addr,
   output logic               pc_en,
   output logic               pc_load,
   output logic [ADDR_W-1:0]  pc_load_val,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_data,
   output logic [INSTR_W-1:0] ir,
   output logic               ir_valid,
   input  logic               ir_ready,
   output logic               halted,
   output logic               fetch_err
);

   fetch_state_t      state, state_nxt;
   logic              is_jmp, is_hlt;
   logic [ADDR_W-1:0] jmp_target;
   logic              ack_hit;
   logic              timeout_hit;

   instr_predecode #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_predecode (
      .ir         (ir),
      .is_jmp     (is_jmp),
      .is_hlt     (is_hlt),
      .jmp_target (jmp_target)
   );

   assign ack_hit = (state == ST_FETCH) && mem_ack;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   // Stall counter: zero on FETCH entry, counts FETCH cycles without ack.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if ((state == ST_FETCH) && !mem_ack)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
         if (timeout_hit)
            err_q <= 1'b1;
      end
   end

   // The edge that would bring the count to TIMEOUT is the timeout edge.
   assign timeout_hit = (state == ST_FETCH) && !mem_ack &&
                        (wait_cnt == CNT_W'(TIMEOUT - 1));
   assign fetch_err   = err_q;
`else
   assign timeout_hit = 1'b0;
   assign fetch_err   = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next state plus the HOLD-exit PC pulses (Mealy, so the PC moves on the
   // consume edge and has the whole WAIT_PC cycle to settle).
   always_comb begin
      state_nxt = state;
      pc_en     = 1'b0;
      pc_load   = 1'b0;
      case (state)
         ST_IDLE:    if (start) state_nxt = ST_FETCH;
         ST_FETCH: begin
            if (mem_ack)          state_nxt = ST_HOLD;
            else if (timeout_hit) state_nxt = ST_HALT;
         end
         ST_HOLD: begin
            if (ir_ready) begin
               if (is_hlt) begin
                  state_nxt = ST_HALT;
               end else begin
                  state_nxt = ST_WAIT_PC;
                  pc_load   = is_jmp;
                  pc_en     = !is_jmp;
               end
            end
         end
         ST_WAIT_PC: state_nxt = ST_FETCH;
         ST_HALT:    state_nxt = ST_HALT;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Address latch and instruction register.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         mem_addr <= '0;
         ir       <= '0;
      end else begin
         if (((state == ST_IDLE) && start) || (state == ST_WAIT_PC))
            mem_addr <= pc_addr;
         if (ack_hit)
            ir <= mem_data;
      end
   end

   assign pc_load_val = pc_load ? jmp_target : '0;
   assign mem_req     = (state == ST_FETCH);
   assign ir_valid    = (state == ST_HOLD);
   assign halted      = (state == ST_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_instr_fetch;

   localparam int AW  = 4;
   localparam int IW  = 8;
   localparam int TMO = 15;

   localparam int P_IDLE   = 0;
   localparam int P_MEM    = 1;
   localparam int P_PRES   = 2;
   localparam int P_SETTLE = 3;
   localparam int P_STOP   = 4;

   logic          clk      = 1'b0;
   logic          res_n    = 1'b1;
   logic          start    = 1'b0;
   logic          mem_ack  = 1'b0;
   logic          ir_ready = 1'b0;
   logic [AW-1:0] pc_addr  = '0;
   logic [IW-1:0] mem_data = '0;

   logic          pc_en, pc_load, mem_req, ir_valid, halted, fetch_err;
   logic [AW-1:0] pc_load_val, mem_addr;
   logic [IW-1:0] ir;

   instr_fetch dut (
      .clk         (clk),
      .res_n       (res_n),
      .start       (start),
      .pc_addr     (pc_addr),
      .pc_en       (pc_en),
      .pc_load     (pc_load),
      .pc_load_val (pc_load_val),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_data    (mem_data),
      .ir          (ir),
      .ir_valid    (ir_valid),
      .ir_ready    (ir_ready),
      .halted      (halted),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model of the fetch unit plus the external program counter.
   int            m_phase = P_IDLE;
   int            m_wait  = 0;
   logic [AW-1:0] m_addr  = '0;
   logic [AW-1:0] pc_reg  = '0;
   logic [IW-1:0] m_ir    = '0;
   logic          m_err   = 1'b0;
   logic [IW-1:0] prog [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [IW-1:0] rand_instr();
      int         r  = $urandom_range(0, 19);
      logic [3:0] op = (r < 5) ? 4'hE : (r == 5) ? 4'hF : 4'($urandom_range(0, 13));
      return {op, 4'($urandom)};
   endfunction

   always @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         m_phase = P_IDLE;
         m_wait  = 0;
         m_addr  = '0;
         m_ir    = '0;
         m_err   = 1'b0;
         pc_reg  = '0;
      end else begin
         case (m_phase)
            P_IDLE: begin
               if (start) begin
                  m_addr  = pc_addr;
                  m_wait  = 0;
                  m_phase = P_MEM;
               end
            end
            P_MEM: begin
               if (mem_ack) begin
                  m_ir    = mem_data;
                  m_phase = P_PRES;
               end else begin
                  m_wait++;
`ifdef FETCH_TIMEOUT_EN
                  if (m_wait == TMO) begin
                     m_err   = 1'b1;
                     m_phase = P_STOP;
                  end
`endif
               end
            end
            P_PRES: begin
               if (ir_ready) begin
                  if (m_ir[7:4] == 4'hF) begin
                     m_phase = P_STOP;
                  end else begin
                     pc_reg  = (m_ir[7:4] == 4'hE) ? m_ir[3:0] : pc_reg + 1'b1;
                     m_phase = P_SETTLE;
                  end
               end
            end
            P_SETTLE: begin
               m_addr  = pc_addr;
               m_wait  = 0;
               m_phase = P_MEM;
            end
            default: ;
         endcase
      end
   end

   // Every-cycle comparison of all outputs against the model.
   logic hs, e_en, e_ld;
   always @(negedge clk) begin
      hs   = (m_phase == P_PRES) && ir_ready;
      e_en = hs && (m_ir[7:4] != 4'hE) && (m_ir[7:4] != 4'hF);
      e_ld = hs && (m_ir[7:4] == 4'hE);
      chk("mem_req",   mem_req,   m_phase == P_MEM);
      chk("ir_valid",  ir_valid,  m_phase == P_PRES);
      chk("halted",    halted,    m_phase == P_STOP);
      chk("pc_en",     pc_en,     e_en);
      chk("pc_load",   pc_load,   e_ld);
      chk("mem_addr",  mem_addr,  m_addr);
      chk("ir",        ir,        m_ir);
      chk("fetch_err", fetch_err, m_err);
      if (e_ld) chk("pc_load_val", pc_load_val, m_ir[3:0]);
   end

   task automatic step();
      @(posedge clk);
      #2;
      pc_addr = pc_reg;
   endtask

   task automatic zeros(input string tag);
      chk({tag, "_ir"},          ir,          0);
      chk({tag, "_mem_addr"},    mem_addr,    0);
      chk({tag, "_pc_load_val"}, pc_load_val, 0);
      chk({tag, "_mem_req"},     mem_req,     0);
      chk({tag, "_ir_valid"},    ir_valid,    0);
      chk({tag, "_pc_en"},       pc_en,       0);
      chk({tag, "_pc_load"},     pc_load,     0);
      chk({tag, "_halted"},      halted,      0);
      chk({tag, "_fetch_err"},   fetch_err,   0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) prog[i] = rand_instr();
      #1 res_n = 1'b0;
      @(negedge clk);
      zeros("rst");
      step();
      res_n = 1'b1;

      // plain opcode with zero-wait memory
      start = 1'b1; mem_ack = 1'b1; mem_data = 8'h12; ir_ready = 1'b1;
      step();
      start = 1'b0;
      @(negedge clk);
      chk("s1_req", mem_req, 1);
      chk("s1_addr", mem_addr, 0);
      step();
      @(negedge clk);
      chk("s1_ir", ir, 8'h12);
      chk("s1_valid", ir_valid, 1);
      chk("s1_pc_en", pc_en, 1);
      chk("s1_pc_load", pc_load, 0);
      step();
      mem_data = 8'hE9; ir_ready = 1'b0;
      @(negedge clk);
      chk("s1_valid_drop", ir_valid, 0);
      chk("s1_pc_en_drop", pc_en, 0);
      step();
      @(negedge clk);
      chk("s1_next_addr", mem_addr, 1);

      // jump held off by ir_ready
      step();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("s2_ir_hold", ir, 8'hE9);
         chk("s2_valid_hold", ir_valid, 1);
         chk("s2_no_pulse", {pc_en, pc_load}, 0);
         step();
      end
      ir_ready = 1'b1; mem_ack = 1'b0; mem_data = 8'h37;
      @(negedge clk);
      chk("s2_pc_load", pc_load, 1);
      chk("s2_target", pc_load_val, 9);
      chk("s2_pc_en", pc_en, 0);
      step();
      step();

      // three wait cycles before ack
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("s3_req", mem_req, 1);
         chk("s3_addr", mem_addr, 9);
         chk("s3_ir_old", ir, 8'hE9);
         step();
         mem_data = 8'($urandom);
      end
      mem_ack = 1'b1; mem_data = 8'h37;
      @(negedge clk);
      chk("s3_req_ack", mem_req, 1);
      step();
      mem_ack = 1'b0; mem_data = 8'hF0;
      @(negedge clk);
      chk("s3_req_off", mem_req, 0);
      chk("s3_ir", ir, 8'h37);

      // halt instruction
      step();
      step();
      mem_ack = 1'b1;
      @(negedge clk);
      chk("s4_addr", mem_addr, 10);
      step();
      mem_ack = 1'b0;
      @(negedge clk);
      chk("s4_ir", ir, 8'hF0);
      chk("s4_no_pulse", {pc_en, pc_load}, 0);
      step();
      for (int i = 0; i < 6; i++) begin
         start = i[0]; mem_ack = ~i[0]; mem_data = 8'($urandom);
         @(negedge clk);
         chk("s4_halted", halted, 1);
         chk("s4_req", mem_req, 0);
         chk("s4_valid", ir_valid, 0);
         step();
      end
      start = 1'b0; mem_ack = 1'b0;

      // reset mid-fetch, late ack ignored
      res_n = 1'b0;
      @(negedge clk);
      zeros("rst2");
      step();
      res_n = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      @(negedge clk);
      chk("s5_req", mem_req, 1);
      #1 res_n = 1'b0;
      #1 zeros("s5_async");
      step();
      res_n = 1'b1; mem_ack = 1'b1; mem_data = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("s5_idle_req", mem_req, 0);
         chk("s5_idle_ir", ir, 0);
         chk("s5_idle_valid", ir_valid, 0);
         step();
      end
      mem_ack = 1'b0;

      // memory never acknowledges
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
         chk("s6_halted", halted, i >= TMO);
         chk("s6_err", fetch_err, i >= TMO);
`else
         chk("s6_req", mem_req, 1);
         chk("s6_err", fetch_err, 0);
`endif
         step();
      end

      // randomized traffic with occasional asynchronous resets
      res_n = 1'b0;
      step();
      res_n = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         start    = ($urandom_range(0, 3) == 0);
         ir_ready = ($urandom_range(0, 9) < 6);
         mem_ack  = ($urandom_range(0, 1) == 1);
         mem_data = ((m_phase == P_MEM) && mem_ack) ? prog[m_addr] : 8'($urandom);
         res_n    = ($urandom_range(0, 99) != 0);
         step();
      end
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit for Richie Jr; the consumer side of the program counter.
- Takes the current PC address and reads program memory over a req/ack handshake.
- Holds the fetched word in an instruction register and presents it to the execute stage with a valid/ready handshake.
- Drives the PC's increment enable and a jump-load request back toward the counter.

Parameters:
- ADDR_W, 4, PC / program-memory address width.
- INSTR_W, 8, instruction width; opcode is the top 4 bits, operand is the low ADDR_W bits.
- TIMEOUT, 15, maximum cycles to wait for mem_ack (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- res_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin fetching; sampled only in IDLE.
- pc_addr  in  ADDR_W  current program counter value.
- pc_en  out  1  one-cycle pulse: PC increments.
- pc_load  out  1  one-cycle pulse: PC loads pc_load_val.
- pc_load_val  out  ADDR_W  jump target.
- mem_req  out  1  read request to program memory.
- mem_addr  out  ADDR_W  read address; registered copy of pc_addr.
- mem_ack  in  1  memory has placed valid data on mem_data.
- mem_data  in  INSTR_W  read data.
- ir  out  INSTR_W  instruction register.
- ir_valid  out  1  ir holds an instruction not yet consumed.
- ir_ready  in  1  execute stage accepts ir.
- halted  out  1  fetch unit is stopped in HALT.
- fetch_err  out  1  sticky timeout flag (feature only; otherwise tied 0).

Behaviour:
- Reset (async, res_n=0):
  - State is IDLE.
  - All outputs are 0: ir, mem_addr, pc_load_val, mem_req, ir_valid, pc_en, pc_load, halted, fetch_err.
  - Reset asserted mid-operation aborts immediately. Any outstanding mem_req drops; a late mem_ack is ignored.
- States: IDLE, FETCH, HOLD, WAIT_PC, HALT.
- IDLE:
  - If start=1, latch mem_addr<=pc_addr and go to FETCH.
- FETCH:
  - mem_req=1 and mem_addr is stable until ack.
  - On the first clk edge where mem_req and mem_ack are both 1: ir<=mem_data, ir_valid<=1, mem_req<=0, go to HOLD.
  - A zero-wait ack (mem_ack already high in the first FETCH cycle) completes in that one cycle.
  - Minimum fetch latency is 1 cycle from entering FETCH to ir_valid.
- HOLD:
  - ir and ir_valid stay stable until ir_valid && ir_ready.
  - On that handshake, decode opcode = ir[INSTR_W-1:INSTR_W-4] and clear ir_valid:
  - JMP (4'hE): pc_load=1 for one cycle, pc_load_val=ir[ADDR_W-1:0], pc_en=0; go to WAIT_PC.
  - HLT (4'hF): no PC pulse; go to HALT.
  - Any other opcode: pc_en=1 for one cycle; go to WAIT_PC.
- WAIT_PC:
  - One cycle so the counter output settles.
  - Then mem_addr<=pc_addr and go to FETCH.
  - Back-to-back throughput is one instruction per 3 cycles with zero-wait memory and ir_ready held high.
- pc_en and pc_load are mutually exclusive and never asserted outside the HOLD-exit cycle.
- PC wrap-around (address 15 -> 0) is the counter's concern. The fetch unit fetches whatever pc_addr presents, with no special case.
- HALT:
  - halted=1, mem_req=0, ir_valid=0.
  - start is ignored; only reset exits.
- A mem_ack that arrives outside FETCH is ignored.
- A change on mem_data while not in FETCH has no effect on ir.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- When defined:
  - A ceil(log2(TIMEOUT+1))-bit wait counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - When the count reaches TIMEOUT, the unit sets fetch_err=1 (sticky until reset), drops mem_req and goes to HALT. ir is unchanged.
- When undefined:
  - No counter is built; FETCH waits indefinitely.
  - fetch_err is constant 0.

Decomposition:
- Shared package richie_jr_pkg contains:
  - opcode constants OP_JMP=4'hE and OP_HLT=4'hF;
  - state encoding for IDLE/FETCH/HOLD/WAIT_PC/HALT;
  - default ADDR_W/INSTR_W.
- One natural sub-module: instr_predecode, purely combinational. It takes ir and produces is_jmp, is_hlt and the jump target, and is reused later by the execute stage.

Test Plan:
- Reset then start=1, pc_addr=0, mem_ack tied 1, mem_data=8'h12, ir_ready=1 -> ir=8'h12, ir_valid for 1 cycle, pc_en pulse, next mem_addr=1 after WAIT_PC.
- mem_data=8'hE9 with ir_ready held low for 4 cycles -> ir/ir_valid stable for 4 cycles; on ready, pc_load=1 with pc_load_val=9 and pc_en=0.
- mem_ack delayed 3 cycles -> mem_req high for exactly 3 cycles plus the ack cycle, mem_addr constant, ir captured only on the ack edge.
- mem_data=8'hF0 -> after handshake halted=1, no pc_en/pc_load; further start and mem_ack pulses give no activity until res_n=0.
- res_n pulsed low mid-FETCH with mem_req=1 -> all outputs 0 asynchronously; an ack arriving after release is ignored while in IDLE.
- With FETCH_TIMEOUT_EN and TIMEOUT=15, mem_ack never asserted -> fetch_err=1 and halted=1 exactly 15 cycles after entering FETCH. Without the macro, mem_req stays high indefinitely.
